// File: rtl/audio_scope.sv
// Oscilloscope capture: zero-crossing (or timeout) trigger, DECIM-sample averaging,
// and a double-buffered waveform memory that swaps only on vsync.
module audio_scope #(
  parameter int DEPTH = 64,
  parameter int DECIM = 4,
  parameter int WIDTH = 6,
  localparam int AW = $clog2(DEPTH),
  localparam int L  = $clog2(DECIM),
  localparam int SW = (L > 0) ? L : 1
) (
  input  logic             clk48,
  input  logic             rst_n,
  input  logic             sample_strobe,
  input  logic [15:0]      audio_sample,
  input  logic             vsync,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             capturing,
  output logic             trig_lock
);

  typedef enum logic [1:0] {WAIT_VS, ARM, CAPT, FULL} state_t;

  state_t            state, next_state;
  logic              prev_msb;
  logic [7:0]        timeout;
  logic [15+L:0]     acc, sum;
  logic [SW-1:0]     sub;
  logic [AW-1:0]     wr_ptr;
  logic              pend_lock;
  logic              disp_bank;

  logic              arm_entry, swap, trigger, crossing, do_acc, last_sub, do_write;

  logic [WIDTH-1:0]  mem [2*DEPTH];

  assign capturing = (state == ARM) || (state == CAPT);
  assign sum       = acc + (16+L)'(audio_sample);
  assign last_sub  = (sub == SW'(DECIM-1));
  assign crossing  = !prev_msb && audio_sample[15];

  // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    next_state = state;
    arm_entry  = 1'b0;
    swap       = 1'b0;
    trigger    = 1'b0;
    do_acc     = 1'b0;
    unique case (state)
      WAIT_VS: if (vsync) begin
        next_state = ARM;
        arm_entry  = 1'b1;
      end
      ARM: if (sample_strobe && (crossing || timeout == 8'hff)) begin
        // The trigger sample is itself the first sample of entry 0.
        trigger    = 1'b1;
        do_acc     = 1'b1;
        next_state = CAPT;
      end
      CAPT: if (sample_strobe) do_acc = 1'b1;
      FULL: if (vsync) begin
        next_state = ARM;
        arm_entry  = 1'b1;
        swap       = 1'b1;
      end
      default: next_state = WAIT_VS;
    endcase
    do_write = do_acc && last_sub;
    if (do_write && wr_ptr == AW'(DEPTH-1)) next_state = FULL;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WAIT_VS;
      prev_msb  <= 1'b1;
      timeout   <= '0;
      acc       <= '0;
      sub       <= '0;
      wr_ptr    <= '0;
      pend_lock <= 1'b0;
      disp_bank <= 1'b0;
      rd_valid  <= 1'b0;
      trig_lock <= 1'b0;
      rd_data   <= '0;
    end else begin
      state <= next_state;

      if (arm_entry) begin
        prev_msb <= 1'b1;
        timeout  <= '0;
        acc      <= '0;
        sub      <= '0;
        wr_ptr   <= '0;
      end

      if (state == ARM && sample_strobe) begin
        prev_msb <= audio_sample[15];
        timeout  <= timeout + 8'd1;
      end
      if (trigger) pend_lock <= crossing;

      if (do_acc) begin
        if (last_sub) begin
          acc <= '0;
          sub <= '0;
          // wr_ptr holds at DEPTH-1 on the final write; only ARM entry rewinds it.
          if (wr_ptr != AW'(DEPTH-1)) wr_ptr <= wr_ptr + AW'(1);
        end else begin
          acc <= sum;
          sub <= sub + SW'(1);
        end
      end

      if (swap) begin
        disp_bank <= ~disp_bank;
        rd_valid  <= 1'b1;
        trig_lock <= pend_lock;
      end

      rd_data <= rd_valid ? mem[{disp_bank, rd_addr}] : '0;
    end
  end

  // NOTE: the waveform memory has no reset; rd_valid hides its contents until a buffer is published.
  always_ff @(posedge clk48) begin
    if (do_write) mem[{~disp_bank, wr_ptr}] <= sum[15+L -: WIDTH];
  end

endmodule

// File: tb/tb_audio_scope.sv
// Directed bench for audio_scope: expected waveform entries are queued as stimulus
// is driven and popped when the published buffer is read back.
module tb_audio_scope;

  logic        clk48 = 1'b0;
  logic        rst_n;
  logic        sample_strobe;
  logic [15:0] audio_sample;
  logic        vsync;
  logic [5:0]  rd_addr;
  logic [5:0]  rd_data;
  logic        rd_valid;
  logic        capturing;
  logic        trig_lock;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [5:0]  exp_q[$];

  always #5 clk48 = ~clk48;

  audio_scope dut (
    .clk48         (clk48),
    .rst_n         (rst_n),
    .sample_strobe (sample_strobe),
    .audio_sample  (audio_sample),
    .vsync         (vsync),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .capturing     (capturing),
    .trig_lock     (trig_lock)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic strobes(input int n, input logic [15:0] s);
    for (int i = 0; i < n; i++) begin
      @(negedge clk48);
      audio_sample  = s;
      sample_strobe = 1'b1;
      @(negedge clk48);
      sample_strobe = 1'b0;
      repeat (2) @(negedge clk48);
    end
  endtask

  task automatic pulse_vsync(input logic with_strobe, input logic [15:0] s);
    @(negedge clk48);
    vsync         = 1'b1;
    sample_strobe = with_strobe;
    audio_sample  = s;
    @(negedge clk48);
    vsync         = 1'b0;
    sample_strobe = 1'b0;
  endtask

  task automatic read_at(input int a, output logic [5:0] d);
    @(negedge clk48);
    rd_addr = 6'(a);
    @(negedge clk48);
    d = rd_data;
  endtask

  // Every entry of a uniform frame is bits [17:12] of one group's 18-bit sum.
  task automatic push_frame(input logic [17:0] grp_sum);
    for (int i = 0; i < 64; i++) exp_q.push_back(grp_sum[17:12]);
  endtask

  task automatic drain_frame(input string tag);
    logic [5:0] d;
    for (int i = 0; i < 64; i++) begin
      read_at(i, d);
      if (exp_q.size() == 0) check({tag, "_underflow"}, 16'd0, 16'd1);
      else check($sformatf("%s[%0d]", tag, i), 16'(d), 16'(exp_q.pop_front()));
    end
  endtask

  initial begin
    logic [5:0] d;
    rst_n = 1'b0; sample_strobe = 1'b0; vsync = 1'b0;
    audio_sample = 16'h8000; rd_addr = '0;
    repeat (3) @(negedge clk48);
    check("rst_rd_data", 16'(rd_data), 16'h0);
    check("rst_rd_valid", 16'(rd_valid), 16'h0);
    check("rst_capturing", 16'(capturing), 16'h0);
    check("rst_trig_lock", 16'(trig_lock), 16'h0);
    @(negedge clk48); rst_n = 1'b1;
    repeat (2) @(negedge clk48);
    check("wait_vs_idle", 16'(capturing), 16'h0);

    // Crossing capture; first FULL must not publish without a second vsync.
    pulse_vsync(1'b0, 16'h8000);
    check("arm_capturing", 16'(capturing), 16'h1);
    strobes(5, 16'h4000);
    push_frame(18'h30000);
    strobes(255, 16'hC000);
    check("cross_not_full_yet", 16'(capturing), 16'h1);
    strobes(1, 16'hC000);
    check("cross_full", 16'(capturing), 16'h0);
    strobes(39, 16'hC000);
    check("nopub_rd_valid", 16'(rd_valid), 16'h0);
    check("nopub_trig_lock", 16'(trig_lock), 16'h0);
    check("nopub_capturing", 16'(capturing), 16'h0);
    for (int i = 0; i < 64; i++) begin
      read_at(i, d);
      check($sformatf("nopub_rd[%0d]", i), 16'(d), 16'h0);
    end

    // Publish; the strobe coincident with this vsync must be dropped.
    pulse_vsync(1'b1, 16'h8000);
    check("pub1_rd_valid", 16'(rd_valid), 16'h1);
    check("pub1_trig_lock", 16'(trig_lock), 16'h1);
    check("pub1_capturing", 16'(capturing), 16'h1);
    drain_frame("pub1");

    // Silence: timeout trigger on the 256th strobe, FULL after the 511th.
    push_frame(18'h20000);
    strobes(510, 16'h8000);
    check("tmo_not_full_yet", 16'(capturing), 16'h1);
    strobes(1, 16'h8000);
    check("tmo_full", 16'(capturing), 16'h0);
    check("tmo_lock_held", 16'(trig_lock), 16'h1);
    pulse_vsync(1'b0, 16'h8000);
    check("tmo_trig_lock", 16'(trig_lock), 16'h0);
    drain_frame("tmo");

    // Averaging: groups 9000,9000,B000,B000 sum to 0x28000.
    push_frame(18'h28000);
    strobes(1, 16'h4000);
    for (int g = 0; g < 64; g++) begin
      strobes(2, 16'h9000);
      strobes(2, 16'hB000);
    end
    check("avg_full", 16'(capturing), 16'h0);
    pulse_vsync(1'b0, 16'h8000);
    check("avg_trig_lock", 16'(trig_lock), 16'h1);
    drain_frame("avg");

    // Buffer A of 0x30, then a 0x2000 capture with a stray vsync at strobe 100.
    push_frame(18'h30000);
    strobes(1, 16'h4000);
    strobes(256, 16'hC000);
    check("bufa_full", 16'(capturing), 16'h0);
    pulse_vsync(1'b0, 16'h8000);
    drain_frame("bufa");
    push_frame(18'h08000);
    strobes(100, 16'h2000);
    pulse_vsync(1'b0, 16'h8000);
    check("stray_capturing", 16'(capturing), 16'h1);
    check("stray_trig_lock", 16'(trig_lock), 16'h1);
    read_at(0, d);  check("stray_rd0", 16'(d), 16'h30);
    read_at(63, d); check("stray_rd63", 16'(d), 16'h30);
    strobes(411, 16'h2000);
    check("bufb_full", 16'(capturing), 16'h0);
    read_at(5, d);  check("bufb_prepub_rd5", 16'(d), 16'h30);
    pulse_vsync(1'b0, 16'h8000);
    check("bufb_trig_lock", 16'(trig_lock), 16'h0);
    drain_frame("bufb");

    // Reset in the middle of a capture.
    strobes(1, 16'h4000);
    strobes(49, 16'hC000);
    @(negedge clk48); rst_n = 1'b0;
    @(negedge clk48);
    check("mrst_rd_valid", 16'(rd_valid), 16'h0);
    check("mrst_rd_data", 16'(rd_data), 16'h0);
    check("mrst_capturing", 16'(capturing), 16'h0);
    check("mrst_trig_lock", 16'(trig_lock), 16'h0);
    rst_n = 1'b1;
    strobes(3, 16'h4000);
    check("mrst_wait_vs", 16'(capturing), 16'h0);
    pulse_vsync(1'b0, 16'h8000);
    push_frame(18'h38000);
    strobes(1, 16'h4000);
    strobes(256, 16'hE000);
    check("mrst_full_rd_valid", 16'(rd_valid), 16'h0);
    read_at(0, d); check("mrst_gated_rd0", 16'(d), 16'h0);
    pulse_vsync(1'b0, 16'h8000);
    check("mrst_pub_rd_valid", 16'(rd_valid), 16'h1);
    check("mrst_pub_trig_lock", 16'(trig_lock), 16'h1);
    drain_frame("mrst");

    check("queue_drained", 16'(exp_q.size()), 16'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
